// File: rtl/seq_gen.sv
// Bit-serial pattern transmitter.
// Sends a captured pattern MSB-first, repeated reps+1 times back-to-back.
module seq_gen #(
  parameter int WIDTH = 16,
  parameter int REPW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [REPW-1:0]  reps,
  input  logic             abort,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [REPW-1:0]  passes_q, passes_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // shreg holds the bits still to follow the one on out
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    shreg_d  = shreg_q;
    passes_d = passes_q;
    bitcnt_d = bitcnt_q;
    out_d    = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = SEND;
            hold_d   = data;
            shreg_d  = {data[WIDTH-2:0], 1'b0};
            passes_d = reps;
            bitcnt_d = '0;
            out_d    = data[WIDTH-1];
            valid_d  = 1'b1;
            busy_d   = 1'b1;
          end
        end
        SEND: begin
          busy_d = 1'b1;
          if (bitcnt_q == LAST) begin
            if (passes_q != '0) begin
              shreg_d  = {hold_q[WIDTH-2:0], 1'b0};
              out_d    = hold_q[WIDTH-1];
              valid_d  = 1'b1;
              bitcnt_d = '0;
              passes_d = passes_q - REPW'(1);
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            out_d    = shreg_q[WIDTH-1];
            valid_d  = 1'b1;
            bitcnt_d = bitcnt_q + CW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      shreg_q  <= '0;
      passes_q <= '0;
      bitcnt_q <= '0;
      out_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      shreg_q  <= shreg_d;
      passes_q <= passes_d;
      bitcnt_q <= bitcnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: expected bits/done queued at stimulus,
// popped by per-instance monitors on the falling edge.
module tb_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort;
  logic [15:0] data;
  logic [3:0]  reps;
  logic        out, valid, busy, done;

  logic        start4;
  logic [3:0]  data4;
  logic [1:0]  reps4;
  logic        out4, valid4, busy4, done4;

  seq_gen #(.WIDTH(16), .REPW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data), .reps(reps),
    .abort(abort), .out(out), .valid(valid), .busy(busy), .done(done)
  );

  seq_gen #(.WIDTH(4), .REPW(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .data(data4), .reps(reps4),
    .abort(abort), .out(out4), .valid(valid4), .busy(busy4), .done(done4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic dn;
    logic b;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  exp_t e16, e4;
  logic [3:0] win4 = 4'h0;
  int match4 = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic push16(input logic [15:0] d, input int nbits,
                        input int passes, input bit with_done);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < nbits; i++)
        q16.push_back('{dn: 1'b0, b: d[15-i]});
    if (with_done) q16.push_back('{dn: 1'b1, b: 1'b0});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drain16();
    int k;
    for (k = 0; k < 400 && q16.size() != 0; k++) tick();
    chk("drain16", q16.size(), 0);
    tick();
  endtask

  task automatic drain4();
    int k;
    for (k = 0; k < 400 && q4.size() != 0; k++) tick();
    chk("drain4", q4.size(), 0);
    tick();
  endtask

  always @(negedge clk) begin
    if (valid || done) begin
      if (q16.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb16_extra: valid=%b done=%b out=%b, want none",
                 valid, done, out);
      end else begin
        e16 = q16.pop_front();
        chk("sb16_kind", done, e16.dn);
        chk("sb16_bit", out, e16.b);
      end
    end
    if (!valid) chk("out_idle16", out, 0);
  end

  always @(negedge clk) begin
    if (valid4) begin
      win4 = {win4[2:0], out4};
      if (win4 == 4'b1101) match4++;
    end
    if (valid4 || done4) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb4_extra: valid=%b done=%b out=%b, want none",
                 valid4, done4, out4);
      end else begin
        e4 = q4.pop_front();
        chk("sb4_kind", done4, e4.dn);
        chk("sb4_bit", out4, e4.b);
      end
    end
    if (!valid4) chk("out_idle4", out4, 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int vcnt;
    rst = 1'b1; start = 1'b0; abort = 1'b0; data = '0; reps = '0;
    start4 = 1'b0; data4 = '0; reps4 = '0;
    tick(); tick();
    chk("rst_out", out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_busy4", busy4, 0);
    rst = 1'b0;
    tick();

    // basic single pass
    data = 16'b1011011010110011; reps = 4'd0;
    push16(data, 16, 1, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_valid0", valid, 1);
    chk("t1_busy0", busy, 1);
    chk("t1_msb", out, 1);
    repeat (15) tick();
    tick();
    chk("t1_done", done, 1);
    chk("t1_done_busy", busy, 1);
    chk("t1_done_valid", valid, 0);
    tick();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_done", done, 0);

    // three passes contiguous
    data = 16'hA5C3; reps = 4'd2;
    push16(data, 16, 3, 1);
    start = 1'b1; tick(); start = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 48; i++) begin
      if (valid) vcnt++;
      tick();
    end
    chk("t2_vcnt", vcnt, 48);
    chk("t2_done", done, 1);
    tick();
    chk("t2_idle_busy", busy, 0);
    drain16();

    // start during SEND ignored
    data = 16'h3C5A; reps = 4'd0;
    push16(data, 16, 1, 1);
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    start = 1'b1; data = 16'hFFFF; reps = 4'hF;
    tick(); start = 1'b0;
    drain16();
    chk("t3_idle_busy", busy, 0);

    // abort at bit 9
    data = 16'h8E71; reps = 4'd1;
    push16(data, 10, 1, 0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_valid", valid, 0);
    chk("t4_out", out, 0);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    repeat (3) tick();
    chk("t4_q_empty", q16.size(), 0);
    data = 16'h6D29; reps = 4'd0;
    push16(data, 16, 1, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_restart_msb", out, 0);
    drain16();

    // reset at bit 3
    data = 16'hF00F; reps = 4'd1;
    push16(data, 4, 1, 0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_out", out, 0);
    chk("t5_valid", valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    tick();

    // start held through DONE, accepted only from IDLE
    data = 16'h1234; reps = 4'd0;
    push16(data, 16, 1, 1);
    start = 1'b1; tick(); start = 1'b0;
    repeat (15) tick();
    start = 1'b1; data = 16'hBEEF;
    push16(16'hBEEF, 16, 1, 1);
    tick();
    chk("t5_done_pulse", done, 1);
    tick();
    chk("t5_gap_busy", busy, 0);
    chk("t5_gap_valid", valid, 0);
    tick(); start = 1'b0;
    chk("t5_new_valid", valid, 1);
    chk("t5_new_busy", busy, 1);
    drain16();

    // narrow instance, max reps
    data4 = 4'b1101; reps4 = 2'd3;
    for (int p = 0; p < 4; p++)
      for (int i = 3; i >= 0; i--)
        q4.push_back('{dn: 1'b0, b: data4[i]});
    q4.push_back('{dn: 1'b1, b: 1'b0});
    start4 = 1'b1; tick(); start4 = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (valid4) vcnt++;
      tick();
    end
    chk("t6_vcnt", vcnt, 16);
    chk("t6_done", done4, 1);
    drain4();
    chk("t6_detect", match4, 4);
    chk("t6_idle_busy", busy4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
